// File: rtl/spm_pkg.sv
// Shared types and constants for the signed serial-parallel multiplier sequencer.
package spm_pkg;

  localparam int unsigned CNT_W_DEF   = 6;
  localparam int unsigned MAX_LEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } spm_state_e;

  // Smallest counter width whose range strictly exceeds max_len.
  function automatic int unsigned min_cnt_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Command/strobe bundle between the command front end and the SPM sequencer.
interface spm_seq_ctrl_if
  import spm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic             start;
  logic [CNT_W-1:0] ser_w;
  logic [CNT_W-1:0] len;
  logic             repeat_mode;
  logic             en;
  logic             abort;
  logic             busy;
  logic             load_en;
  logic             shift_en;
  logic             sext_hold;
  logic             last_bit;
  logic             done;
  logic [CNT_W-1:0] count;

  modport master (
    output start, ser_w, len, repeat_mode, en, abort,
    input  busy, load_en, shift_en, sext_hold, last_bit, done, count
  );

  modport slave (
    input  start, ser_w, len, repeat_mode, en, abort,
    output busy, load_en, shift_en, sext_hold, last_bit, done, count
  );

endinterface

// File: rtl/spm_step_cnt.sv
// Enable/clear step counter that saturates at a programmable terminal value.
module spm_step_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;
  logic         w_tc;

  assign w_tc = (r_count == i_term);

  // Clear wins; otherwise advance until the terminal value is reached, then hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_tc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = w_tc;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencing controller for the SPM shift/adder chain: load, shift, sign-extend, done.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic           clk,
  input  logic           reset,
  spm_seq_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

  spm_state_e       r_state;
  spm_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_ser;
  logic             r_busy;
  logic             r_load_en;
  logic             r_done;

  logic [CNT_W-1:0] w_len_clamp;
  logic [CNT_W-1:0] w_ser_sel;
  logic [CNT_W-1:0] w_term;
  logic [CNT_W-1:0] w_count;
  logic             w_tc;
  logic             w_latch;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_run;
  logic             w_shift;

  // Clamp requested lengths at latch time; a zero serial width means a 1-bit operand.
  always_comb begin
    w_len_clamp = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    w_ser_sel   = bus.ser_w;
    if (bus.ser_w == '0) begin
      w_ser_sel = CNT_W'(1);
    end else if (bus.ser_w > w_len_clamp) begin
      w_ser_sel = w_len_clamp;
    end
  end

  assign w_term = r_len - CNT_W'(1);

  // Lengths are captured only on an accepted start and reused for repeat passes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len <= '0;
      r_ser <= '0;
    end else if (w_latch) begin
      r_len <= w_len_clamp;
      r_ser <= w_ser_sel;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and counter control; abort overrides stepping and completion.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = bus.abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.en) begin
          if (w_tc) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.repeat_mode) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_cnt_clr = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
  end

  spm_step_cnt #(
    .W (CNT_W)
  ) u_step_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_inc),
    .i_term  (w_term),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  // Registered status strobes derived from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_load_en <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_load_en <= (w_state_nxt == ST_LOAD);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign w_run   = (r_state == ST_RUN);
  assign w_shift = w_run & bus.en & ~bus.abort;

  assign bus.busy      = r_busy;
  assign bus.load_en   = r_load_en;
  assign bus.done      = r_done;
  assign bus.count     = w_count;
  assign bus.shift_en  = w_shift;
  assign bus.last_bit  = w_shift & w_tc;
  assign bus.sext_hold = w_run & (w_count >= (r_ser - CNT_W'(1)));

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Randomized bench for spm_seq_ctrl against a per-transaction trace model.
module tb_spm_seq_ctrl;

  localparam int unsigned CW = 6;
  localparam int unsigned ML = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spm_seq_ctrl_if #(.CNT_W(CW)) bus ();

  spm_seq_ctrl #(
    .CNT_W   (CW),
    .MAX_LEN (ML)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input int ln, input int sw, input bit rep,
                       input bit en_i, input bit ab);
    bus.start       = st;
    bus.len         = CW'(ln);
    bus.ser_w       = CW'(sw);
    bus.repeat_mode = rep;
    bus.en          = en_i;
    bus.abort       = ab;
  endtask

  task automatic expect_out(input string tag, input bit e_busy, input bit e_load,
                            input bit e_shift, input bit e_sext, input bit e_last,
                            input bit e_done, input int e_cnt);
    #1;
    check({tag, "_busy"},  32'(bus.busy),      32'(e_busy));
    check({tag, "_load"},  32'(bus.load_en),   32'(e_load));
    check({tag, "_shift"}, 32'(bus.shift_en),  32'(e_shift));
    check({tag, "_sext"},  32'(bus.sext_hold), 32'(e_sext));
    check({tag, "_last"},  32'(bus.last_bit),  32'(e_last));
    check({tag, "_done"},  32'(bus.done),      32'(e_done));
    check({tag, "_count"}, 32'(bus.count),     32'(e_cnt));
  endtask

  // Noise on command inputs while busy; none of it may have an effect.
  task automatic drive_busy(input bit rep, input bit en_i, input bit ab);
    drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
          rep, en_i, ab);
  endtask

  task automatic idle_check(input string tag);
    drive(1'b0, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    expect_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // One command: start, then 'passes' load/shift/done passes (repeat_mode held in all
  // but the last DONE). abort_where: 0 none, 1 in LOAD, 2 in RUN at step abort_k, 3 in DONE.
  task automatic run_txn(input int len, input int ser_w, input int passes, input int en_pct,
                         input int stall_k, input int stall_n, input int abort_where,
                         input int abort_k);
    int  L, S, k, stalled, guard, cyc, load_cyc, n_idle, n_shift, pass;
    bit  en_v, ab, rep;

    cyc = 0;
    drive(1'b1, len, ser_w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    expect_out("start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    next_cycle(); cyc++;

    if (len == 0) begin
      idle_check("zero_len");
      return;
    end

    L = (len > int'(ML)) ? int'(ML) : len;
    S = (ser_w == 0) ? 1 : ((ser_w > L) ? L : ser_w);
    pass = 1;

    forever begin
      load_cyc = cyc;
      ab = (abort_where == 1);
      drive_busy(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
      expect_out("load", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      next_cycle(); cyc++;
      if (ab) begin
        idle_check("abort_load");
        return;
      end

      k = 0; stalled = 0; guard = 0; n_idle = 0; n_shift = 0;
      forever begin
        if (stall_n > 0 && k == stall_k && stalled < stall_n) begin
          en_v = 1'b0;
          stalled++;
        end else begin
          en_v = (int'($urandom_range(1, 100)) <= en_pct);
        end
        ab = (abort_where == 2 && k == abort_k);
        drive_busy(1'($urandom_range(0, 1)), en_v, ab);
        expect_out("run", 1'b1, 1'b0, en_v && !ab, k >= S - 1, en_v && !ab && (k == L - 1),
                   1'b0, k);
        next_cycle(); cyc++;
        if (ab) begin
          idle_check("abort_run");
          return;
        end
        if (en_v) begin
          n_shift++;
          if (k == L - 1) break;
          k++;
        end else begin
          n_idle++;
        end
        guard++;
        if (guard > 4000) begin
          check("run_bound", 32'(guard), 32'd0);
          return;
        end
      end

      rep = (pass < passes);
      ab  = (abort_where == 3);
      drive_busy(rep, 1'($urandom_range(0, 1)), ab);
      expect_out("done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, L - 1);
      check("shift_total", 32'(n_shift), 32'(L));
      check("done_latency", 32'(cyc - load_cyc), 32'(1 + L + n_idle));
      next_cycle(); cyc++;
      if (ab || !rep) begin
        idle_check(ab ? "abort_done" : "after_done");
        return;
      end
      pass++;
    end
  endtask

  int ln, sw, ps, ep, sk, sn, aw, ak, w;

  initial begin
    reset = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;

    run_txn(8, 4, 1, 100, 0, 0, 0, 0);      // basic
    run_txn(4, 2, 1, 100, 2, 3, 0, 0);      // stall at count 2
    run_txn(40, 10, 1, 100, 0, 0, 0, 0);    // clamp to 32
    run_txn(0, 3, 1, 100, 0, 0, 0, 0);      // zero length ignored
    run_txn(3, 2, 2, 100, 0, 0, 0, 0);      // repeat, then drop
    run_txn(8, 4, 1, 100, 0, 0, 2, 5);      // abort at count 5
    run_txn(1, 0, 1, 100, 0, 0, 0, 0);      // single step, ser_w 0
    run_txn(5, 9, 1, 100, 0, 0, 1, 0);      // abort in LOAD
    run_txn(2, 1, 3, 100, 0, 0, 3, 0);      // abort in DONE despite repeat

    // Async reset between edges during RUN clears everything at once.
    drive(1'b1, 8, 4, 1'b0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) next_cycle();
    expect_out("pre_reset", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    reset = 1'b1;
    expect_out("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    next_cycle();
    expect_out("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    next_cycle();
    idle_check("post_reset");

    for (int t = 0; t < 60; t++) begin
      ln = ($urandom_range(0, 3) == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 12));
      sw = int'($urandom_range(0, 63));
      ps = int'($urandom_range(1, 3));
      ep = int'($urandom_range(40, 100));
      sn = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      sk = int'($urandom_range(0, 8));
      w  = int'($urandom_range(0, 9));
      aw = (w < 6) ? 0 : ((w < 7) ? 1 : ((w < 9) ? 2 : 3));
      ak = int'($urandom_range(0, 12));
      run_txn(ln, sw, ps, ep, sk, sn, aw, ak);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spm_seq_ctrl.md
Name: spm_seq_ctrl

Overview:
Parametrised sequencing controller for the signed serial-parallel multiplier datapath. It generalises the fixed saturating step counter:
- runtime-programmable operand and product lengths;
- start/busy/done handshake;
- stall, abort and auto-repeat modes;
- per-cycle strobes: parallel load, shift, sign-extension hold, last bit.

It sits between the top-level command interface and the SPM shift/adder chain.

Parameters:
CNT_W, 6, width of step counter and length inputs; 2^CNT_W must exceed MAX_LEN
MAX_LEN, 32, maximum number of shift cycles per product; larger requests clamp to MAX_LEN

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a new multiplication; sampled only in IDLE
ser_w  input  CNT_W  serial-operand width in bits (sign bit is bit ser_w-1)
len  input  CNT_W  total shift cycles (product width)
repeat_mode  input  1  1 = after DONE, restart immediately using latched lengths
en  input  1  step enable; 0 stalls RUN (counter and shift_en frozen)
abort  input  1  synchronous abort; return to IDLE without done
busy  output  1  high in LOAD, RUN, DONE
load_en  output  1  one-cycle strobe: load parallel operand, clear partial sums
shift_en  output  1  shift the SPM chain this cycle
sext_hold  output  1  serial input register holds sign bit (sign extension)
last_bit  output  1  high on the final shift cycle
done  output  1  one-cycle completion pulse
count  output  CNT_W  current step index

Behaviour:
- Reset (async, active-high): state=IDLE; count=0; all strobes and busy=0; latched lengths=0.
- States: IDLE, LOAD, RUN, DONE; 2-bit encoding; all outputs registered except shift_en/last_bit/sext_hold, which decode state and count.
- IDLE:
  - start=1 and len!=0 -> latch L=min(len,MAX_LEN) and S=min(ser_w,L) -> LOAD.
  - start with len==0 is ignored and stays in IDLE.
  - ser_w==0 is treated as S=1.
- LOAD: load_en=1 for exactly one cycle; count=0 -> RUN. en is not consulted.
- RUN:
  - shift_en = en.
  - When en=1: count increments; if count==L-1 -> DONE and count holds L-1 (saturates, no wrap).
  - When en=0: count, state and outputs hold; shift_en=0.
  - last_bit = en & (count==L-1).
  - sext_hold = (count >= S-1), independent of en.
- Latency: start to first shift_en = 2 cycles (IDLE->LOAD->RUN). With en tied 1, done asserts L+2 cycles after the start sample.
- DONE:
  - done=1 for one cycle.
  - repeat_mode=0 -> IDLE.
  - repeat_mode=1 -> LOAD with the same L and S; start and new len/ser_w are ignored.
- abort:
  - In LOAD, RUN or DONE: next state IDLE, count=0, no done pulse.
  - Has priority over en and over the DONE transition.
  - Ignored in IDLE.
- start while busy: ignored; len/ser_w changes while busy have no effect.
- L==1: RUN lasts one enabled cycle with last_bit=1 and sext_hold=1.
- Width: count compares use CNT_W-bit unsigned arithmetic; the clamp is a combinational compare at latch time.

Decomposition:
- Shared package spm_pkg holds:
  - state enum type (IDLE, LOAD, RUN, DONE);
  - default CNT_W/MAX_LEN constants;
  - a function computing the minimum CNT_W for a given MAX_LEN.
- One natural sub-module: spm_step_cnt, a generalised enable/clear counter with saturating terminal value and a terminal-count flag. The FSM instantiates it.
- Strobe decode stays in the top.

Test Plan:
- Basic: reset, then start with len=8, ser_w=4, en=1, repeat=0:
  - load_en at cycle 1;
  - shift_en cycles 2-9;
  - sext_hold from count=3;
  - last_bit at count=7;
  - done at cycle 10;
  - busy=0 at cycle 11.
- Stall: len=4, en low for 3 cycles at count=2:
  - count holds 2 and shift_en=0 during the stall;
  - exactly 4 shift_en pulses in total;
  - done delayed by 3 cycles.
- Clamp and zero:
  - start with len=40 gives 32 shift cycles and count saturates at 31;
  - start with len=0 keeps busy=0 and no load_en.
- Repeat mode: len=3, repeat_mode=1 for two passes:
  - done, then load_en the next cycle;
  - second pass has 3 shifts;
  - drop repeat_mode during the second pass -> IDLE after done.
- Abort and reset mid-run:
  - abort at count=5 (len=8) -> IDLE next cycle, no done, count=0;
  - async reset asserted mid-RUN between clock edges clears all outputs immediately.
- Edge: len=1, ser_w=0 -> one shift with last_bit=1 and sext_hold=1; done one cycle later.
